// File: rtl/idiv_pkg.sv
// Shared divider definitions: request type-field layout (common with the decoder)
// and FSM state encoding.
package idiv_pkg;
  localparam int IDIVTYPEBITSZ = 2;
  // Bit offsets inside the type field, relative to 2*ARCHBITSZ+CLOG2GPRCNT.
  localparam int IDIVSIGNED    = 1;
  localparam int IDIVREM       = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/idiv_step.sv
// One combinational radix-2 restoring step: shift in dividend msb, trial-subtract,
// and shift the resulting quotient bit into the dividend/quotient register.
module idivstep #(
  parameter int W = 16
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] dvd_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] dvd_o
);
  logic [W:0] sh, diff;
  logic       ge;

  assign sh   = {rem_i, dvd_i[W-1]};
  assign diff = sh - {1'b0, dvs_i};
  // rem_i < dvs_i keeps sh-dvs within (-2^W, 2^W), so the top bit is a clean borrow.
  assign ge   = ~diff[W];

  assign rem_o = ge ? diff[W-1:0] : sh[W-1:0];
  assign dvd_o = {dvd_i[W-2:0], ge};
endmodule

// File: rtl/idiv.sv
// Iterative restoring integer divider (signed/unsigned, quotient or remainder).
// Optional early-out for trivial divides under `define PUIDIVFASTPATH_EN.
module idiv
  import idiv_pkg::*;
#(
  parameter int ARCHBITSZ = 16,
  parameter int GPRCNT    = 32,
  localparam int CLOG2GPRCNT = $clog2(GPRCNT)
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         stb_i,
  input  logic [(2*ARCHBITSZ)+CLOG2GPRCNT+IDIVTYPEBITSZ-1:0] data_i,
  output logic                                         rdy_o,
  input  logic                                         ostb_i,
  output logic                                         ordy_o,
  output logic [ARCHBITSZ-1:0]                         data_o,
  output logic [CLOG2GPRCNT-1:0]                       gprid_o
);
  localparam int W    = ARCHBITSZ;
  localparam int TB   = 2*W + CLOG2GPRCNT;
  localparam int CNTW = $clog2(W+1);

  logic [1:0]             state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic                   rem_sel_q, rem_sel_d;
  logic                   dvdneg_q, dvdneg_d;
  logic                   dvsneg_q, dvsneg_d;
  logic [CLOG2GPRCNT-1:0] gprid_q, gprid_d;
  logic [W-1:0]           dvd_q, dvd_d;   // dividend, becomes quotient
  logic [W-1:0]           dvs_q, dvs_d;
  logic [W-1:0]           rem_q, rem_d;

  logic                   req_sgn;
  logic [W-1:0]           req_dvd, req_dvs, dvd_abs, dvs_abs;
  logic [W-1:0]           step_rem, step_dvd;
  logic [W-1:0]           qfix, rfix;

  assign req_sgn = data_i[TB+IDIVSIGNED];
  assign req_dvd = data_i[2*W-1:W];
  assign req_dvs = data_i[W-1:0];
  assign dvd_abs = (req_sgn && req_dvd[W-1]) ? -req_dvd : req_dvd;
  assign dvs_abs = (req_sgn && req_dvs[W-1]) ? -req_dvs : req_dvs;

  idivstep #(.W(W)) u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .dvd_o (step_dvd)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_sel_d = rem_sel_q;
    dvdneg_d  = dvdneg_q;
    dvsneg_d  = dvsneg_q;
    gprid_d   = gprid_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    case (state_q)
      ST_IDLE: if (stb_i) begin
        state_d   = ST_CALC;
        cnt_d     = '0;
        rem_sel_d = data_i[TB+IDIVREM];
        dvdneg_d  = req_sgn & req_dvd[W-1];
        dvsneg_d  = req_sgn & req_dvs[W-1];
        gprid_d   = data_i[TB-1:2*W];
        dvd_d     = dvd_abs;
        dvs_d     = dvs_abs;
        rem_d     = '0;
`ifdef PUIDIVFASTPATH_EN
        // Preset the counter to its terminal value so CALC exits on the next edge.
        if (dvs_abs == '0 || dvd_abs < dvs_abs) begin
          cnt_d = CNTW'(W);
          dvd_d = (dvs_abs == '0) ? '1 : '0;
          rem_d = dvd_abs;
        end
`endif
      end
      ST_CALC: begin
        if (cnt_q == CNTW'(W)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          dvd_d = step_dvd;
          rem_d = step_rem;
        end
      end
      ST_DONE: if (ostb_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      dvdneg_q  <= 1'b0;
      dvsneg_q  <= 1'b0;
      gprid_q   <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_sel_q <= rem_sel_d;
      dvdneg_q  <= dvdneg_d;
      dvsneg_q  <= dvsneg_d;
      gprid_q   <= gprid_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
    end
  end

  // Divide-by-zero leaves quotient all-ones; remainder re-negation restores the dividend.
  assign qfix = ((dvdneg_q ^ dvsneg_q) && dvs_q != '0) ? -dvd_q : dvd_q;
  assign rfix = dvdneg_q ? -rem_q : rem_q;

  assign rdy_o   = (state_q == ST_IDLE);
  assign ordy_o  = (state_q == ST_DONE);
  assign data_o  = rem_sel_q ? rfix : qfix;
  assign gprid_o = gprid_q;
endmodule

// File: tb/tb_idiv.sv
// Scoreboard bench for idiv: driver pushes model results, monitor pops on ordy_o.
module tb_idiv;
  localparam int W  = 16;
  localparam int G  = 32;
  localparam int GW = 5;
  localparam int DW = 2*W + GW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stb = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rdy, ostb, ordy;
  logic [W-1:0]  dout;
  logic [GW-1:0] gprid;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0]  res;
    logic [GW-1:0] g;
    int            lat;
    int            acc;
    int            hold;
  } exp_t;
  exp_t sbq[$];

  idiv #(.ARCHBITSZ(W), .GPRCNT(G)) dut (
    .clk_i(clk), .rst_i(rst_n), .stb_i(stb), .data_i(din), .rdy_o(rdy),
    .ostb_i(ostb), .ordy_o(ordy), .data_o(dout), .gprid_o(gprid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic with the divide-by-zero and overflow rules.
  task automatic model(input bit sg, input bit rm, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output int lat);
    int sa, sb, aa, ab;
    logic [W-1:0] q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 0) begin
      q = '1; r = a;
    end else if (sg) begin
      if (sa == -32768 && sb == -1) begin q = 16'h8000; r = '0; end
      else begin q = W'(sa / sb); r = W'(sa % sb); end
    end else begin
      q = a / b; r = a % b;
    end
    res = rm ? r : q;
    aa = sg ? (sa < 0 ? -sa : sa) : int'(a);
    ab = sg ? (sb < 0 ? -sb : sb) : int'(b);
    lat = W + 1;
`ifdef PUIDIVFASTPATH_EN
    if (b == 0 || aa < ab) lat = 1;
`else
    if (aa < 0 || ab < 0) lat = 0;  // unreachable: magnitudes are non-negative
`endif
  endtask

  task automatic issue(bit sg, bit rm, logic [GW-1:0] g, logic [W-1:0] a, logic [W-1:0] b,
                       int hold, bit push, bit junk);
    exp_t e;
    int t;
    t = 0;
    while (!rdy && t < 200) begin @(negedge clk); t++; end
    if (!rdy) begin
      n_cmp++; n_bad++;
      $display("FAIL rdy_timeout: rdy_o stayed 0 for %0d cycles", t);
      return;
    end
    stb = 1'b1;
    din = {sg, rm, g, a, b};
    model(sg, rm, a, b, e.res, e.lat);
    e.g = g; e.acc = cyc + 1; e.hold = hold;
    if (push) sbq.push_back(e);
    @(negedge clk);
    stb = 1'b0;
    if (junk) begin
      repeat (3) begin
        stb = 1'b1;
        din = DW'({$urandom, $urandom});
        @(negedge clk);
      end
      stb = 1'b0;
    end
  endtask

  // Monitor / consumer.
  initial begin
    exp_t e;
    ostb = 1'b0;
    forever begin
      @(negedge clk);
      if (ordy) begin
        if (sbq.size() == 0) begin
          chk("unexpected_ordy", 32'(ordy), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("data_o", 32'(dout), 32'(e.res));
          chk("gprid_o", 32'(gprid), 32'(e.g));
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("rdy_in_done", 32'(rdy), 32'd0);
          repeat (e.hold) begin
            @(negedge clk);
            chk("hold_ordy", 32'(ordy), 32'd1);
            chk("hold_data", 32'(dout), 32'(e.res));
            chk("hold_rdy", 32'(rdy), 32'd0);
          end
          ostb = 1'b1;
          @(negedge clk);
          ostb = 1'b0;
          chk("rdy_after_consume", 32'({rdy, ordy}), 32'b10);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] a, b;
    int t, k;
    #2;
    chk("reset_rdy", 32'(rdy), 32'd1);
    chk("reset_ordy", 32'(ordy), 32'd0);
    chk("reset_data", 32'(dout), 32'd0);
    chk("reset_gprid", 32'(gprid), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 0, 5, 16'd100, 16'd7, 0, 1, 1);
    issue(0, 1, 5, 16'd100, 16'd7, 1, 1, 0);
    issue(1, 0, 3, 16'hFFF9, 16'h0002, 0, 1, 0);
    issue(1, 1, 3, 16'hFFF9, 16'h0002, 2, 1, 0);
    issue(0, 0, 7, 16'h1234, 16'h0000, 0, 1, 0);
    issue(0, 1, 7, 16'h1234, 16'h0000, 0, 1, 0);
    issue(1, 0, 8, 16'h1234, 16'h0000, 0, 1, 0);
    issue(1, 1, 8, 16'h1234, 16'h0000, 0, 1, 0);
    issue(1, 1, 9, 16'hF234, 16'h0000, 0, 1, 0);
    issue(1, 0, 31, 16'h8000, 16'hFFFF, 10, 1, 0);
    issue(1, 1, 30, 16'h8000, 16'hFFFF, 0, 1, 0);
    issue(0, 0, 1, 16'd3, 16'd9, 0, 1, 0);
    issue(0, 1, 1, 16'd3, 16'd9, 0, 1, 0);
    issue(0, 0, 2, 16'd200, 16'd9, 0, 1, 0);
    issue(0, 1, 2, 16'd200, 16'd9, 0, 1, 0);
    issue(0, 0, 4, 16'hFFFF, 16'hFFFF, 0, 1, 0);
    issue(0, 1, 4, 16'hFFFE, 16'hFFFF, 0, 1, 0);

    // Reset in the middle of CALC: result discarded, next request from cold.
    t = 0;
    while ((sbq.size() != 0 || !rdy) && t < 500) begin @(negedge clk); t++; end
    issue(0, 0, 6, 16'h1234, 16'h0007, 0, 0, 0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midcalc_rst_rdy", 32'(rdy), 32'd1);
    chk("midcalc_rst_ordy", 32'(ordy), 32'd0);
    chk("midcalc_rst_data", 32'(dout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 0, 10, 16'd50, 16'd5, 0, 1, 0);

    for (int i = 0; i < 300; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      k = $urandom_range(0, 9);
      if (k == 0) b = '0;
      else if (k < 4) b = W'($urandom_range(1, 20));
      else if (k == 4) begin a = 16'h8000; b = 16'hFFFF; end
      else if (k == 5) a = W'($urandom_range(0, 30));
      issue(1'($urandom), 1'($urandom), GW'($urandom), a, b, $urandom_range(0, 3), 1, 0);
    end

    t = 0;
    while ((sbq.size() != 0 || !rdy) && t < 500) begin @(negedge clk); t++; end
    if (sbq.size() != 0) chk("drain_timeout", 32'(sbq.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
